// File: rtl/dds_bus_if.sv
// DDS backplane bus: 7-bit byte address, 16-bit word data, active-low strobes, master reset and FUD.
interface dds_bus_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 16
);
  // Handshake: the master holds cs_n/addr/data stable around a strobe. A falling w_strobe_n is one
  // write; read data is valid while dds_data_oe=1, i.e. while r_strobe_n is held low.
  logic                  dds_cs_n;
  logic [ADDR_WIDTH-1:0] dds_addr;
  logic [DATA_WIDTH-1:0] dds_data_i;
  logic [DATA_WIDTH-1:0] dds_data_o;
  logic                  dds_data_oe;
  logic                  dds_w_strobe_n;
  logic                  dds_r_strobe_n;
  logic                  dds_master_reset;
  logic                  dds_fud;

  modport master (
    output dds_cs_n, dds_addr, dds_data_i, dds_w_strobe_n, dds_r_strobe_n, dds_master_reset, dds_fud,
    input  dds_data_o, dds_data_oe
  );

  modport slave (
    input  dds_cs_n, dds_addr, dds_data_i, dds_w_strobe_n, dds_r_strobe_n, dds_master_reset, dds_fud,
    output dds_data_o, dds_data_oe
  );
endinterface

// File: rtl/dds_bus_responder.sv
// AD9914-style parallel-port emulator: 128-byte shadow file, word reads/writes, shadow->active on FUD.
module dds_bus_responder #(
  parameter int ADDR_WIDTH  = 7,
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clock,
  input  logic          reset_n,
  dds_bus_if.slave      bus,
  output logic [31:0]   ftw,
  output logic [15:0]   pow,
  output logic [15:0]   asf,
  output logic          update_pulse,
  output logic [15:0]   write_count,
  output logic [15:0]   fud_count,
  output logic [1:0]    state_dbg
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int BYTE  = DATA_WIDTH / 2;

  localparam logic [ADDR_WIDTH-1:0] A_FTW3 = ADDR_WIDTH'('h2F);
  localparam logic [ADDR_WIDTH-1:0] A_FTW2 = ADDR_WIDTH'('h2E);
  localparam logic [ADDR_WIDTH-1:0] A_FTW1 = ADDR_WIDTH'('h2D);
  localparam logic [ADDR_WIDTH-1:0] A_FTW0 = ADDR_WIDTH'('h2C);
  localparam logic [ADDR_WIDTH-1:0] A_POW1 = ADDR_WIDTH'('h31);
  localparam logic [ADDR_WIDTH-1:0] A_POW0 = ADDR_WIDTH'('h30);
  localparam logic [ADDR_WIDTH-1:0] A_ASF1 = ADDR_WIDTH'('h33);
  localparam logic [ADDR_WIDTH-1:0] A_ASF0 = ADDR_WIDTH'('h32);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_MRESET} state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] cs_sync, w_sync, r_sync, mr_sync, fud_sync;
  logic                   w_hist, fud_hist;
  logic [BYTE-1:0]        shadow    [DEPTH];
  logic [BYTE-1:0]        active    [DEPTH];
  logic [BYTE-1:0]        shadow_wr [DEPTH];

  logic cs_s, w_s, r_s, mr_s, fud_s;
  logic mreset_act, w_fall, fud_rise, rd_cond;
  logic [ADDR_WIDTH-1:0] a_hi, a_lo;

  assign cs_s  = cs_sync[SYNC_STAGES-1];
  assign w_s   = w_sync[SYNC_STAGES-1];
  assign r_s   = r_sync[SYNC_STAGES-1];
  assign mr_s  = mr_sync[SYNC_STAGES-1];
  assign fud_s = fud_sync[SYNC_STAGES-1];

  assign mreset_act = mr_s & ~cs_s;
  assign w_fall     = w_hist & ~w_s & ~cs_s & ~mreset_act;
  assign fud_rise   = fud_s & ~fud_hist & ~mreset_act;
  assign rd_cond    = ~r_s & ~cs_s & w_s & ~mreset_act;

  // Word at A spans bytes A (high) and A-1 (low); A-1 wraps 0x00 -> 0x7F.
  assign a_hi = bus.dds_addr;
  assign a_lo = bus.dds_addr - ADDR_WIDTH'(1);

  assign state_dbg = state;

  // Post-write view of the shadow file, so a same-cycle FUD transfers the new bytes.
  always_comb begin
    shadow_wr = shadow;
    if (w_fall) begin
      shadow_wr[a_hi] = bus.dds_data_i[DATA_WIDTH-1:BYTE];
      shadow_wr[a_lo] = bus.dds_data_i[BYTE-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cs_sync         <= '1;
      w_sync          <= '1;
      r_sync          <= '1;
      mr_sync         <= '0;
      fud_sync        <= '0;
      w_hist          <= 1'b1;
      fud_hist        <= 1'b0;
      shadow          <= '{default: '0};
      active          <= '{default: '0};
      ftw             <= '0;
      pow             <= '0;
      asf             <= '0;
      update_pulse    <= 1'b0;
      write_count     <= '0;
      fud_count       <= '0;
      bus.dds_data_o  <= '0;
      bus.dds_data_oe <= 1'b0;
      state           <= ST_IDLE;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], bus.dds_cs_n};
      w_sync   <= {w_sync[SYNC_STAGES-2:0], bus.dds_w_strobe_n};
      r_sync   <= {r_sync[SYNC_STAGES-2:0], bus.dds_r_strobe_n};
      mr_sync  <= {mr_sync[SYNC_STAGES-2:0], bus.dds_master_reset};
      fud_sync <= {fud_sync[SYNC_STAGES-2:0], bus.dds_fud};
      w_hist   <= w_s;
      fud_hist <= fud_s;
      update_pulse <= 1'b0;

      if (mreset_act) begin
        shadow          <= '{default: '0};
        active          <= '{default: '0};
        ftw             <= '0;
        pow             <= '0;
        asf             <= '0;
        bus.dds_data_o  <= '0;
        bus.dds_data_oe <= 1'b0;
        state           <= ST_MRESET;
      end else begin
        shadow <= shadow_wr;
        if (w_fall) write_count <= write_count + 16'd1;
        if (fud_rise) begin
          active       <= shadow_wr;
          update_pulse <= 1'b1;
          fud_count    <= fud_count + 16'd1;
        end

        ftw <= {active[A_FTW3], active[A_FTW2], active[A_FTW1], active[A_FTW0]};
        pow <= {active[A_POW1], active[A_POW0]};
        asf <= {active[A_ASF1], active[A_ASF0]};

        if (rd_cond) begin
          bus.dds_data_oe <= 1'b1;
          bus.dds_data_o  <= {shadow[a_hi], shadow[a_lo]};
        end else begin
          bus.dds_data_oe <= 1'b0;
          bus.dds_data_o  <= '0;
        end

        if (w_fall)       state <= ST_WRITE;
        else if (rd_cond) state <= ST_READ;
        else              state <= ST_IDLE;
      end
    end
  end
endmodule
